axi_lite_arbiter_2m: RTL and testbench

Two-master AXI-Lite arbiter sharing a single AXI-Lite slave port, which in our SoC is the `axi_lite_interface` register front-end.
- Write and read paths are arbitrated independently. Each has its own grant FSM and round-robin pointer.
- A grant is held from address acceptance until the response handshake completes, so transactions from different masters never interleave on one path.
- The block is pure control: after a grant, every data signal passes through combinationally.

---
 rtl/axi_lite_arbiter_2m.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_lite_arbiter_2m.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter_2m.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter_2m
// Two-master AXI-Lite arbiter in front of a single AXI-Lite slave port.
// Write and read paths are arbitrated independently. Each path has its own
// IDLE/BUSY grant FSM and round-robin pointer. A grant is held from address
// acceptance until the response handshake, and all data passes through
// combinationally from the granted master.
//
// Build option:
//   AXIL_ARB_FIXED_PRIO_EN  master 0 always wins a tie; the pointer is removed.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   i_m_aw*/o_m_awready         per-master write address channel (bit/slice n)
//   i_m_w*/o_m_wready           per-master write data channel
//   o_m_bvalid/i_m_bready       per-master write response channel
//   i_m_ar*/o_m_arready         per-master read address channel
//   o_m_rdata/o_m_rvalid/i_m_rready  per-master read data channel
//   o_s_* / i_s_*               shared slave-side AXI-Lite channels
//   o_wr_grant, o_rd_grant      one-hot current grant per path (status)
// ---------------------------------------------------------------------------
module axi_lite_arbiter_2m #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [2*ADDR_WIDTH-1:0] i_m_awaddr,
  input  logic [1:0]              i_m_awvalid,
  output logic [1:0]              o_m_awready,
  input  logic [2*DATA_WIDTH-1:0] i_m_wdata,
  input  logic [7:0]              i_m_wstrb,
  input  logic [1:0]              i_m_wvalid,
  output logic [1:0]              o_m_wready,
  output logic [1:0]              o_m_bvalid,
  input  logic [1:0]              i_m_bready,
  input  logic [2*ADDR_WIDTH-1:0] i_m_araddr,
  input  logic [1:0]              i_m_arvalid,
  output logic [1:0]              o_m_arready,
  output logic [2*DATA_WIDTH-1:0] o_m_rdata,
  output logic [1:0]              o_m_rvalid,
  input  logic [1:0]              i_m_rready,
  output logic [ADDR_WIDTH-1:0]   o_s_awaddr,
  output logic                    o_s_awvalid,
  input  logic                    i_s_awready,
  output logic [DATA_WIDTH-1:0]   o_s_wdata,
  output logic [3:0]              o_s_wstrb,
  output logic                    o_s_wvalid,
  input  logic                    i_s_wready,
  input  logic                    i_s_bvalid,
  output logic                    o_s_bready,
  output logic [ADDR_WIDTH-1:0]   o_s_araddr,
  output logic                    o_s_arvalid,
  input  logic                    i_s_arready,
  input  logic [DATA_WIDTH-1:0]   i_s_rdata,
  input  logic                    i_s_rvalid,
  output logic                    o_s_rready,
  output logic [1:0]              o_wr_grant,
  output logic [1:0]              o_rd_grant
);

  localparam int unsigned STRB_WIDTH = 4;
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_BUSY    = 1'b1;

  // ---------------------------------------------------------------- write path
  logic [0:0] wr_state, wr_state_nxt;
  logic       wr_gnt, wr_gnt_nxt;
  logic       wr_pick;
`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic       wr_ptr, wr_ptr_nxt;
`endif

  // Winner among current AW requesters; only meaningful while some request is up
  always_comb begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
    wr_pick = ~i_m_awvalid[0];
`else
    wr_pick = (i_m_awvalid == 2'b11) ? wr_ptr : i_m_awvalid[1];
`endif
  end

  // Write grant FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state <= ST_IDLE;
      wr_gnt   <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      wr_ptr   <= 1'b0;
`endif
    end else begin
      wr_state <= wr_state_nxt;
      wr_gnt   <= wr_gnt_nxt;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      wr_ptr   <= wr_ptr_nxt;
`endif
    end
  end

  // Write grant FSM: next state; grant released after the B handshake
  always_comb begin
    wr_state_nxt = wr_state;
    wr_gnt_nxt   = wr_gnt;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    wr_ptr_nxt   = wr_ptr;
`endif
    if (wr_state == ST_IDLE) begin
      if (|i_m_awvalid) begin
        wr_state_nxt = ST_BUSY;
        wr_gnt_nxt   = wr_pick;
      end
    end else begin
      if (i_s_bvalid && o_s_bready) begin
        wr_state_nxt = ST_IDLE;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        wr_ptr_nxt   = ~wr_gnt;
`endif
      end
    end
  end

  // Write routing: everything is zero unless a master holds the write grant
  always_comb begin
    o_s_awaddr  = '0;
    o_s_awvalid = 1'b0;
    o_s_wdata   = '0;
    o_s_wstrb   = '0;
    o_s_wvalid  = 1'b0;
    o_s_bready  = 1'b0;
    o_m_awready = 2'b00;
    o_m_wready  = 2'b00;
    o_m_bvalid  = 2'b00;
    o_wr_grant  = 2'b00;
    if (wr_state == ST_BUSY) begin
      o_wr_grant[wr_gnt] = 1'b1;
      if (wr_gnt) begin
        o_s_awaddr = i_m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        o_s_wdata  = i_m_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
        o_s_wstrb  = i_m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH];
      end else begin
        o_s_awaddr = i_m_awaddr[ADDR_WIDTH-1:0];
        o_s_wdata  = i_m_wdata[DATA_WIDTH-1:0];
        o_s_wstrb  = i_m_wstrb[STRB_WIDTH-1:0];
      end
      o_s_awvalid         = i_m_awvalid[wr_gnt];
      o_s_wvalid          = i_m_wvalid[wr_gnt];
      o_s_bready          = i_m_bready[wr_gnt];
      o_m_awready[wr_gnt] = i_s_awready;
      o_m_wready[wr_gnt]  = i_s_wready;
      o_m_bvalid[wr_gnt]  = i_s_bvalid;
    end
  end

  // ----------------------------------------------------------------- read path
  logic [0:0] rd_state, rd_state_nxt;
  logic       rd_gnt, rd_gnt_nxt;
  logic       rd_pick;
`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic       rd_ptr, rd_ptr_nxt;
`endif

  // Winner among current AR requesters
  always_comb begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
    rd_pick = ~i_m_arvalid[0];
`else
    rd_pick = (i_m_arvalid == 2'b11) ? rd_ptr : i_m_arvalid[1];
`endif
  end

  // Read grant FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= ST_IDLE;
      rd_gnt   <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rd_ptr   <= 1'b0;
`endif
    end else begin
      rd_state <= rd_state_nxt;
      rd_gnt   <= rd_gnt_nxt;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rd_ptr   <= rd_ptr_nxt;
`endif
    end
  end

  // Read grant FSM: next state; grant released after the R handshake
  always_comb begin
    rd_state_nxt = rd_state;
    rd_gnt_nxt   = rd_gnt;
`ifndef AXIL_ARB_FIXED_PRIO_EN
    rd_ptr_nxt   = rd_ptr;
`endif
    if (rd_state == ST_IDLE) begin
      if (|i_m_arvalid) begin
        rd_state_nxt = ST_BUSY;
        rd_gnt_nxt   = rd_pick;
      end
    end else begin
      if (i_s_rvalid && o_s_rready) begin
        rd_state_nxt = ST_IDLE;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        rd_ptr_nxt   = ~rd_gnt;
`endif
      end
    end
  end

  // Read routing; rdata is replicated to both masters, qualified by rvalid
  always_comb begin
    o_s_araddr  = '0;
    o_s_arvalid = 1'b0;
    o_s_rready  = 1'b0;
    o_m_arready = 2'b00;
    o_m_rvalid  = 2'b00;
    o_m_rdata   = '0;
    o_rd_grant  = 2'b00;
    if (rd_state == ST_BUSY) begin
      o_rd_grant[rd_gnt] = 1'b1;
      if (rd_gnt) begin
        o_s_araddr = i_m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      end else begin
        o_s_araddr = i_m_araddr[ADDR_WIDTH-1:0];
      end
      o_s_arvalid         = i_m_arvalid[rd_gnt];
      o_s_rready          = i_m_rready[rd_gnt];
      o_m_arready[rd_gnt] = i_s_arready;
      o_m_rvalid[rd_gnt]  = i_s_rvalid;
      o_m_rdata           = {i_s_rdata, i_s_rdata};
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arbiter_2m
// Scoreboard bench for axi_lite_arbiter_2m. A master driver and a slave model
// run as independent processes; directed stimulus pushes expected responses
// into queues that a monitor pops on every B/R handshake at the master side.
// Honours AXIL_ARB_FIXED_PRIO_EN for the read-ordering expectations.
// ---------------------------------------------------------------------------
module tb_axi_lite_arbiter_2m;

  logic        clk;
  logic        resetn;
  logic [63:0] i_m_awaddr;
  logic [1:0]  i_m_awvalid;
  logic [1:0]  o_m_awready;
  logic [63:0] i_m_wdata;
  logic [7:0]  i_m_wstrb;
  logic [1:0]  i_m_wvalid;
  logic [1:0]  o_m_wready;
  logic [1:0]  o_m_bvalid;
  logic [1:0]  i_m_bready;
  logic [63:0] i_m_araddr;
  logic [1:0]  i_m_arvalid;
  logic [1:0]  o_m_arready;
  logic [63:0] o_m_rdata;
  logic [1:0]  o_m_rvalid;
  logic [1:0]  i_m_rready;
  logic [31:0] o_s_awaddr;
  logic        o_s_awvalid;
  logic        i_s_awready;
  logic [31:0] o_s_wdata;
  logic [3:0]  o_s_wstrb;
  logic        o_s_wvalid;
  logic        i_s_wready;
  logic        i_s_bvalid;
  logic        o_s_bready;
  logic [31:0] o_s_araddr;
  logic        o_s_arvalid;
  logic        i_s_arready;
  logic [31:0] i_s_rdata;
  logic        i_s_rvalid;
  logic        o_s_rready;
  logic [1:0]  o_wr_grant;
  logic [1:0]  o_rd_grant;

  axi_lite_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_m_awaddr(i_m_awaddr), .i_m_awvalid(i_m_awvalid), .o_m_awready(o_m_awready),
    .i_m_wdata(i_m_wdata), .i_m_wstrb(i_m_wstrb), .i_m_wvalid(i_m_wvalid),
    .o_m_wready(o_m_wready), .o_m_bvalid(o_m_bvalid), .i_m_bready(i_m_bready),
    .i_m_araddr(i_m_araddr), .i_m_arvalid(i_m_arvalid), .o_m_arready(o_m_arready),
    .o_m_rdata(o_m_rdata), .o_m_rvalid(o_m_rvalid), .i_m_rready(i_m_rready),
    .o_s_awaddr(o_s_awaddr), .o_s_awvalid(o_s_awvalid), .i_s_awready(i_s_awready),
    .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wvalid(o_s_wvalid),
    .i_s_wready(i_s_wready), .i_s_bvalid(i_s_bvalid), .o_s_bready(o_s_bready),
    .o_s_araddr(o_s_araddr), .o_s_arvalid(o_s_arvalid), .i_s_arready(i_s_arready),
    .i_s_rdata(i_s_rdata), .i_s_rvalid(i_s_rvalid), .o_s_rready(o_s_rready),
    .o_wr_grant(o_wr_grant), .o_rd_grant(o_rd_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // OR of every DUT output, used for the all-zero checks
  wire any_out = |{o_m_awready, o_m_wready, o_m_bvalid, o_m_arready, o_m_rdata,
                   o_m_rvalid, o_s_awaddr, o_s_awvalid, o_s_wdata, o_s_wstrb,
                   o_s_wvalid, o_s_bready, o_s_araddr, o_s_arvalid, o_s_rready,
                   o_wr_grant, o_rd_grant};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endfunction

  // ------------------------------------------------------------ command queues
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wcmd_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_wr_t;

  typedef struct {
    int          m;
    logic [31:0] data;
  } exp_rd_t;

  wcmd_t       wq0[$];
  wcmd_t       wq1[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  exp_wr_t     exp_wr[$];
  exp_rd_t     exp_rd[$];

  logic [1:0] w_act;
  logic [1:0] r_act;

  // ------------------------------------------------------------ master driver
  logic [1:0] m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
  initial begin
    wcmd_t       wc;
    logic [31:0] ra;
    logic        got;
    i_m_awaddr  = '0;
    i_m_awvalid = '0;
    i_m_wdata   = '0;
    i_m_wstrb   = '0;
    i_m_wvalid  = '0;
    i_m_bready  = 2'b11;
    i_m_araddr  = '0;
    i_m_arvalid = '0;
    i_m_rready  = 2'b11;
    w_act       = '0;
    r_act       = '0;
    forever begin
      @(negedge clk);
      m_aw_hs = i_m_awvalid & o_m_awready;
      m_w_hs  = i_m_wvalid & o_m_wready;
      m_b_hs  = o_m_bvalid & i_m_bready;
      m_ar_hs = i_m_arvalid & o_m_arready;
      m_r_hs  = o_m_rvalid & i_m_rready;
      @(posedge clk);
      #1;
      if (!resetn) begin
        i_m_awvalid = '0;
        i_m_wvalid  = '0;
        i_m_arvalid = '0;
        w_act       = '0;
        r_act       = '0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (m_aw_hs[m]) i_m_awvalid[m] = 1'b0;
          if (m_w_hs[m])  i_m_wvalid[m]  = 1'b0;
          if (m_b_hs[m])  w_act[m]       = 1'b0;
          if (m_ar_hs[m]) i_m_arvalid[m] = 1'b0;
          if (m_r_hs[m])  r_act[m]       = 1'b0;
          got = 1'b0;
          if (!w_act[m]) begin
            if (m == 0 && wq0.size() > 0) begin wc = wq0.pop_front(); got = 1'b1; end
            if (m == 1 && wq1.size() > 0) begin wc = wq1.pop_front(); got = 1'b1; end
          end
          if (got) begin
            i_m_awaddr[m*32 +: 32] = wc.addr;
            i_m_wdata[m*32 +: 32]  = wc.data;
            i_m_wstrb[m*4 +: 4]    = wc.strb;
            i_m_awvalid[m]         = 1'b1;
            i_m_wvalid[m]          = 1'b1;
            w_act[m]               = 1'b1;
          end
          got = 1'b0;
          if (!r_act[m]) begin
            if (m == 0 && rq0.size() > 0) begin ra = rq0.pop_front(); got = 1'b1; end
            if (m == 1 && rq1.size() > 0) begin ra = rq1.pop_front(); got = 1'b1; end
          end
          if (got) begin
            i_m_araddr[m*32 +: 32] = ra;
            i_m_arvalid[m]         = 1'b1;
            r_act[m]               = 1'b1;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- slave model
  // Read data = 0xC0DE_0000 | addr[15:0]; B one cycle after both AW and W.
  logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, got_aw, got_w;
  logic [31:0] s_ar_addr;
  initial begin
    i_s_awready = 1'b0;
    i_s_wready  = 1'b0;
    i_s_bvalid  = 1'b0;
    i_s_arready = 1'b0;
    i_s_rvalid  = 1'b0;
    i_s_rdata   = '0;
    got_aw      = 1'b0;
    got_w       = 1'b0;
    forever begin
      @(negedge clk);
      s_aw_hs   = o_s_awvalid & i_s_awready;
      s_w_hs    = o_s_wvalid & i_s_wready;
      s_b_hs    = i_s_bvalid & o_s_bready;
      s_ar_hs   = o_s_arvalid & i_s_arready;
      s_r_hs    = i_s_rvalid & o_s_rready;
      s_ar_addr = o_s_araddr;
      @(posedge clk);
      #1;
      if (!resetn) begin
        i_s_awready = 1'b0;
        i_s_wready  = 1'b0;
        i_s_bvalid  = 1'b0;
        i_s_arready = 1'b0;
        i_s_rvalid  = 1'b0;
        got_aw      = 1'b0;
        got_w       = 1'b0;
      end else begin
        if (s_aw_hs) got_aw = 1'b1;
        if (s_w_hs)  got_w  = 1'b1;
        if (s_b_hs)  i_s_bvalid = 1'b0;
        if (got_aw && got_w && !i_s_bvalid) begin
          i_s_bvalid = 1'b1;
          got_aw     = 1'b0;
          got_w      = 1'b0;
        end
        i_s_awready = !got_aw;
        i_s_wready  = !got_w;
        if (s_r_hs) i_s_rvalid = 1'b0;
        if (s_ar_hs) begin
          i_s_rvalid = 1'b1;
          i_s_rdata  = 32'hC0DE_0000 | {16'h0000, s_ar_addr[15:0]};
        end
        i_s_arready = !i_s_rvalid;
      end
    end
  end

  // ------------------------------------------------------- scoreboard monitor
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  initial begin
    exp_wr_t ew;
    exp_rd_t er;
    int      mm;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (o_s_awvalid && i_s_awready) cap_awaddr = o_s_awaddr;
        if (o_s_wvalid && i_s_wready) begin
          cap_wdata = o_s_wdata;
          cap_wstrb = o_s_wstrb;
        end
        if (|(o_m_bvalid & i_m_bready)) begin
          check("b_valid_vs_grant", 64'(o_m_bvalid), 64'(o_wr_grant));
          if (exp_wr.size() == 0) begin
            fail_now("b_unexpected_response");
          end else begin
            ew = exp_wr.pop_front();
            mm = o_m_bvalid[1] ? 1 : 0;
            check("b_master", 64'(mm), 64'(ew.m));
            check("w_slave_addr", 64'(cap_awaddr), 64'(ew.addr));
            check("w_slave_data", 64'(cap_wdata), 64'(ew.data));
            check("w_slave_strb", 64'(cap_wstrb), 64'(ew.strb));
          end
        end
        if (|(o_m_rvalid & i_m_rready)) begin
          check("r_valid_vs_grant", 64'(o_m_rvalid), 64'(o_rd_grant));
          if (exp_rd.size() == 0) begin
            fail_now("r_unexpected_response");
          end else begin
            er = exp_rd.pop_front();
            mm = o_m_rvalid[1] ? 1 : 0;
            check("r_master", 64'(mm), 64'(er.m));
            check("r_data", 64'(o_m_rdata[mm*32 +: 32]), 64'(er.data));
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic issue_wr(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit expect_b);
    wcmd_t   c;
    exp_wr_t e;
    c.addr = a; c.data = d; c.strb = s;
    if (m == 0) wq0.push_back(c); else wq1.push_back(c);
    if (expect_b) begin
      e.m = m; e.addr = a; e.data = d; e.strb = s;
      exp_wr.push_back(e);
    end
  endtask

  task automatic expect_rd(input int m, input logic [31:0] d);
    exp_rd_t e;
    e.m = m; e.data = d;
    exp_rd.push_back(e);
  endtask

  function automatic bit all_done();
    return exp_wr.size() == 0 && exp_rd.size() == 0 && wq0.size() == 0 &&
           wq1.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
           w_act == 2'b00 && r_act == 2'b00;
  endfunction

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (all_done()) break;
    end
    if (k == 300) fail_now({name, "_timeout"});
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
  endtask

  // Request seen at cycle N (grant still 0); grant and slave AW valid at N+1
  task automatic latency_check(input int m, input logic [31:0] a);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_m_awvalid[m]) break;
    end
    if (k == 20) begin
      fail_now("lat_request_timeout");
    end else begin
      check("lat_grant_at_N", 64'(o_wr_grant), 64'(0));
      @(negedge clk);
      check("lat_grant_at_N1", 64'(o_wr_grant), 64'(2'b01 << m));
      check("lat_s_awvalid_at_N1", 64'(o_s_awvalid), 64'(1));
      check("lat_s_awaddr_at_N1", 64'(o_s_awaddr), 64'(a));
      check("lat_m_awready_at_N1", 64'(o_m_awready), 64'(2'b01 << m));
    end
  endtask

  // ------------------------------------------------------------------ stimulus
  logic [1:0] glog[$];
  logic [1:0] gexp[5];
  initial begin
    int k;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grants", 64'({o_wr_grant, o_rd_grant}), 64'(0));
    check("rst_all_outputs_zero", 64'(any_out), 64'(0));
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single write from m0
    issue_wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    latency_check(0, 32'h0000_0010);
    drain("single_write");

    // Simultaneous writes right after reset: m0 first, then m1
    do_reset();
    glog.delete();
    glog.push_back(o_wr_grant);
    issue_wr(0, 32'h0000_0020, 32'h1111_1111, 4'hF, 1'b1);
    issue_wr(1, 32'h0000_0024, 32'h2222_2222, 4'hC, 1'b1);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_wr_grant != glog[$]) glog.push_back(o_wr_grant);
      if (all_done() && o_wr_grant == 2'b00) break;
    end
    if (k == 200) fail_now("sim_write_timeout");
    gexp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    check("wr_grant_seq_len", 64'(glog.size()), 64'(5));
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check("wr_grant_seq", 64'(glog[i]), 64'(gexp[i]));
    repeat (2) @(negedge clk);

    // Four reads per master, issued back-to-back
    for (int i = 0; i < 4; i++) begin
      rq0.push_back(32'h0000_0100 + 32'(4*i));
      rq1.push_back(32'h0000_0200 + 32'(4*i));
    end
`ifdef AXIL_ARB_FIXED_PRIO_EN
    expect_rd(0, 32'hC0DE_0100); expect_rd(0, 32'hC0DE_0104);
    expect_rd(0, 32'hC0DE_0108); expect_rd(0, 32'hC0DE_010C);
    expect_rd(1, 32'hC0DE_0200); expect_rd(1, 32'hC0DE_0204);
    expect_rd(1, 32'hC0DE_0208); expect_rd(1, 32'hC0DE_020C);
`else
    expect_rd(0, 32'hC0DE_0100); expect_rd(1, 32'hC0DE_0200);
    expect_rd(0, 32'hC0DE_0104); expect_rd(1, 32'hC0DE_0204);
    expect_rd(0, 32'hC0DE_0108); expect_rd(1, 32'hC0DE_0208);
    expect_rd(0, 32'hC0DE_010C); expect_rd(1, 32'hC0DE_020C);
`endif
    drain("reads");

    // m0 write concurrent with m1 read
    issue_wr(0, 32'h0000_0040, 32'h1234_5678, 4'h3, 1'b1);
    rq1.push_back(32'h0000_0300);
    expect_rd(1, 32'hC0DE_0300);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_wr_grant != 2'b00 || o_rd_grant != 2'b00) break;
    end
    if (k == 20) fail_now("concurrent_grant_timeout");
    check("concurrent_wr_grant", 64'(o_wr_grant), 64'(2'b01));
    check("concurrent_rd_grant", 64'(o_rd_grant), 64'(2'b10));
    drain("concurrent");

    // Reset while m1 holds the write grant; no B may follow
    issue_wr(1, 32'h0000_0050, 32'hAAAA_5555, 4'hF, 1'b0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_wr_grant != 2'b00) break;
    end
    if (k == 20) fail_now("midrst_grant_timeout");
    check("midrst_grant_before", 64'(o_wr_grant), 64'(2'b10));
    #2 resetn = 1'b0;
    #1;
    check("midrst_all_outputs_zero", 64'(any_out), 64'(0));
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (2) @(negedge clk);
    issue_wr(0, 32'h0000_0060, 32'hCAFE_F00D, 4'h5, 1'b1);
    latency_check(0, 32'h0000_0060);
    drain("after_reset_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish in time");
  end

endmodule
